// File: rtl/sr_pkg.sv
// Shared encodings for the SR command driver: command opcodes and FSM states.
package sr_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_SET = 2'b01,
    OP_RST = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    CHECK = 2'b10
  } state_e;

endpackage

// File: rtl/sr_cmd_fifo.sv
// Synchronous FIFO with pointer-MSB wrap; count = wr_ptr - rd_ptr.
module sr_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     wr_data,
  input  logic             pop,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + CNT_W'(do_push);
    rd_ptr_d = rd_ptr_q + CNT_W'(do_pop);
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; pointers alone define validity, so clearing it would only cost area.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sr_cmd_driver.sv
// Buffers set/reset/nop commands, pulses S/R one cycle each and checks
// the three SR implementations against a reference model.
module sr_cmd_driver
  import sr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  output logic             S,
  output logic             R,
  input  logic             Q_jk,
  input  logic             Q_d,
  input  logic             Q_t,
  input  logic             err_clr,
  output logic             expected_q,
  output logic             mismatch,
  output logic             illegal_cmd,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  state_e     state_q, state_d;
  logic       s_q, s_d, r_q, r_d;
  logic       exp_q, exp_d;
  logic       mismatch_q, mismatch_d;
  logic       illegal_q, illegal_d;
  logic       xfer, push, ill_xfer, pop;
  logic       full, empty;
  logic [1:0] head;

  assign cmd_ready = !full;
  assign xfer      = cmd_valid && cmd_ready;
  assign push      = xfer && (cmd_op != OP_ILL);
  assign ill_xfer  = xfer && (cmd_op == OP_ILL);

  sr_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (cmd_op),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    s_d        = 1'b0;
    r_d        = 1'b0;
    exp_d      = exp_q;
    pop        = 1'b0;
    // A new error in the same cycle as err_clr still sets the flag.
    mismatch_d = mismatch_q & ~err_clr;
    illegal_d  = (illegal_q & ~err_clr) | ill_xfer;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          s_d     = (head == OP_SET);
          r_d     = (head == OP_RST);
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (s_q)      exp_d = 1'b1;
        else if (r_q) exp_d = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        mismatch_d = mismatch_d | (Q_jk != exp_q) | (Q_d != exp_q) | (Q_t != exp_q);
        if (!empty) begin
          pop     = 1'b1;
          s_d     = (head == OP_SET);
          r_d     = (head == OP_RST);
          state_d = DRIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      exp_q      <= 1'b0;
      mismatch_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      r_q        <= r_d;
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      illegal_q  <= illegal_d;
    end
  end

  assign S           = s_q;
  assign R           = r_q;
  assign expected_q  = exp_q;
  assign mismatch    = mismatch_q;
  assign illegal_cmd = illegal_q;
  assign busy        = (state_q != IDLE) || !empty;

  a_s_r_exclusive : assert property (@(posedge clk) disable iff (!rst) !(s_q && r_q));

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed bench for sr_cmd_driver with behavioural JK/D/T-style SR stages on Q.
module tb_sr_cmd_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic       S, R, Q_jk, Q_d, Q_t;
  logic       err_clr;
  logic       expected_q, mismatch, illegal_cmd, busy;
  logic [2:0] fifo_count;

  logic q_jk_m, q_d_m, q_t_m, force_t;
  int   n_checks = 0;
  int   n_fail   = 0;

  sr_cmd_driver #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .S           (S),
    .R           (R),
    .Q_jk        (Q_jk),
    .Q_d         (Q_d),
    .Q_t         (Q_t),
    .err_clr     (err_clr),
    .expected_q  (expected_q),
    .mismatch    (mismatch),
    .illegal_cmd (illegal_cmd),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // SR stage models, reset by the same event as the driver.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_jk_m <= 1'b0;
      q_d_m  <= 1'b0;
      q_t_m  <= 1'b0;
    end else begin
      q_jk_m <= S ? 1'b1 : (R ? 1'b0 : q_jk_m);
      q_d_m  <= S | (~R & q_d_m);
      q_t_m  <= q_t_m ^ ((S & ~q_t_m) | (R & q_t_m));
    end
  end

  assign Q_jk = q_jk_m;
  assign Q_d  = q_d_m;
  assign Q_t  = force_t ? 1'b0 : q_t_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
  endtask

  // SET from empty/IDLE with expected_q starting at 0.
  task automatic single_set(input string tag);
    check({tag, " exp_before"}, expected_q, 0);
    push_op(2'b01);
    check({tag, " count_after_push"}, fifo_count, 1);
    check({tag, " S_not_yet"}, S, 0);
    tick();
    check({tag, " S_pulse"}, S, 1);
    check({tag, " R_low"}, R, 0);
    check({tag, " count_popped"}, fifo_count, 0);
    tick();
    check({tag, " S_dropped"}, S, 0);
    check({tag, " exp_set"}, expected_q, 1);
    tick();
    check({tag, " mismatch"}, mismatch, 0);
    check({tag, " busy_idle"}, busy, 0);
  endtask

  initial begin
    logic [1:0] t2_op  [4]  = '{2'b01, 2'b10, 2'b00, 2'b01};
    logic       t2_s   [10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    logic       t2_r   [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    logic       t2_exp [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    int         t2_cnt [10] = '{1, 1, 2, 2, 2, 1, 1, 0, 0, 0};
    int         t3_cnt [10] = '{1, 1, 2, 2, 3, 3, 4, 3, 4, 3};
    logic       t3_rdy [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1};
    bit         both_seen;
    int         waited;

    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    err_clr   = 1'b0;
    force_t   = 1'b0;
    #12;
    check("rst S", S, 0);
    check("rst R", R, 0);
    check("rst expected_q", expected_q, 0);
    check("rst mismatch", mismatch, 0);
    check("rst illegal", illegal_cmd, 0);
    check("rst busy", busy, 0);
    check("rst count", fifo_count, 0);
    check("rst ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: single SET
    single_set("t1");

    // 2: back-to-back SET, RESET, NOP, SET
    both_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i < 4);
      cmd_op    = (i < 4) ? t2_op[i] : 2'b00;
      tick();
      if (S && R) both_seen = 1'b1;
      check($sformatf("t2 S[%0d]", i), S, t2_s[i]);
      check($sformatf("t2 R[%0d]", i), R, t2_r[i]);
      check($sformatf("t2 exp[%0d]", i), expected_q, t2_exp[i]);
      check($sformatf("t2 count[%0d]", i), fifo_count, t2_cnt[i]);
    end
    cmd_valid = 1'b0;
    check("t2 S_and_R", both_seen, 0);
    check("t2 mismatch", mismatch, 0);

    // 3: continuous NOP pushes fill the FIFO; full blocks push even on a pop
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      tick();
      check($sformatf("t3 count[%0d]", i), fifo_count, t3_cnt[i]);
      check($sformatf("t3 ready[%0d]", i), cmd_ready, t3_rdy[i]);
      check($sformatf("t3 S[%0d]", i), S, 0);
    end
    cmd_valid = 1'b0;
    waited = 0;
    while (busy && waited < 40) begin
      tick();
      waited++;
    end
    check("t3 drain_timeout", busy, 0);
    check("t3 count_drained", fifo_count, 0);
    check("t3 exp_hold", expected_q, 1);
    check("t3 mismatch", mismatch, 0);

    // 4: illegal op is consumed, not queued; error wins over err_clr
    push_op(2'b11);
    check("t4 illegal", illegal_cmd, 1);
    check("t4 count", fifo_count, 0);
    check("t4 busy", busy, 0);
    tick();
    check("t4 no_S", S, 0);
    check("t4 no_R", R, 0);
    err_clr = 1'b1;
    push_op(2'b11);
    err_clr = 1'b0;
    check("t4 err_wins", illegal_cmd, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t4 cleared", illegal_cmd, 0);

    // 5: Q_t stuck low after SET
    force_t = 1'b1;
    push_op(2'b01);
    tick();
    check("t5 S_pulse", S, 1);
    tick();
    check("t5 mismatch_pre", mismatch, 0);
    tick();
    check("t5 mismatch_set", mismatch, 1);
    force_t = 1'b0;
    tick();
    tick();
    check("t5 mismatch_sticky", mismatch, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5 mismatch_cleared", mismatch, 0);

    // 6: asynchronous reset while S is high
    push_op(2'b01);
    tick();
    check("t6 S_before", S, 1);
    check("t6 exp_before", expected_q, 1);
    #1;
    rst = 1'b0;
    #1;
    check("t6 S_async", S, 0);
    check("t6 count", fifo_count, 0);
    check("t6 exp", expected_q, 0);
    check("t6 busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    single_set("t6 post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
